// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter producing a registered one-hot grant under valid/ready
module rr_grant_arbiter #(
  parameter int REQ_WIDTH   = 4,
  parameter int INDEX_WIDTH = $clog2(REQ_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REQ_WIDTH-1:0]   req_in,
  input  logic                   grant_ready_in,
  input  logic                   flush_in,
  output logic [REQ_WIDTH-1:0]   grant_out,
  output logic [INDEX_WIDTH-1:0] grant_index_out,
  output logic                   grant_valid_out
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]             state;
  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] next_ptr;
  logic [INDEX_WIDTH:0]   idle_win;
  logic [INDEX_WIDTH:0]   hs_win;
  logic                   handshake;

  // First set request scanning from start upward with wrap-around.
  // Returns {found, index}; the loop runs backwards so the earliest
  // position in scan order is the last one written.
  function automatic logic [INDEX_WIDTH:0] search(
    input logic [REQ_WIDTH-1:0]   req,
    input logic [INDEX_WIDTH-1:0] start
  );
    logic [INDEX_WIDTH:0]   result;
    logic [INDEX_WIDTH-1:0] pos_idx;
    int                     pos;
    result = '0;
    for (int k = REQ_WIDTH - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= REQ_WIDTH) pos = pos - REQ_WIDTH;
      pos_idx = pos[INDEX_WIDTH-1:0];
      if (req[pos_idx]) result = {1'b1, pos_idx};
    end
    return result;
  endfunction

  // Candidate winners: one from the current pointer (used when idle), one
  // from the pointer just past the served source (used on handshake).
  always_comb begin
    next_ptr  = (grant_index_out == INDEX_WIDTH'(REQ_WIDTH - 1)) ? '0 : grant_index_out + 1'b1;
    handshake = grant_valid_out && grant_ready_in;
    idle_win  = search(req_in, ptr);
    hs_win    = search(req_in, next_ptr);
  end

  // Grant registers, priority pointer and state; flush beats handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      grant_out       <= '0;
      grant_index_out <= '0;
      grant_valid_out <= 1'b0;
    end else if (flush_in) begin
      state           <= IDLE;
      grant_out       <= '0;
      grant_index_out <= '0;
      grant_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_win[INDEX_WIDTH]) begin
            state           <= GRANT;
            grant_out       <= REQ_WIDTH'(1) << idle_win[INDEX_WIDTH-1:0];
            grant_index_out <= idle_win[INDEX_WIDTH-1:0];
            grant_valid_out <= 1'b1;
          end
        end
        default: begin
          if (handshake) begin
            ptr <= next_ptr;
            if (hs_win[INDEX_WIDTH]) begin
              state           <= GRANT;
              grant_out       <= REQ_WIDTH'(1) << hs_win[INDEX_WIDTH-1:0];
              grant_index_out <= hs_win[INDEX_WIDTH-1:0];
              grant_valid_out <= 1'b1;
            end else begin
              state           <= IDLE;
              grant_out       <= '0;
              grant_index_out <= '0;
              grant_valid_out <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_in;
  logic       grant_ready_in;
  logic       flush_in;
  logic [3:0] grant_out;
  logic [1:0] grant_index_out;
  logic       grant_valid_out;

  logic [1:0] data_out;
  logic       data_out_valid;

  int vectors     = 0;
  int miscompares = 0;
  bit inv_on      = 1'b0;

  rr_grant_arbiter #(.REQ_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_in          (req_in),
    .grant_ready_in  (grant_ready_in),
    .flush_in        (flush_in),
    .grant_out       (grant_out),
    .grant_index_out (grant_index_out),
    .grant_valid_out (grant_valid_out)
  );

  always #5 clk = ~clk;

  // data_selector stand-in: SEL_WIDTH=4, DATA_WIDTH=2, data_in[i]=i
  always_comb begin
    data_out       = 2'd0;
    data_out_valid = |grant_out;
    for (int i = 0; i < 4; i++)
      if (grant_out[i]) data_out = 2'(i);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic v);
    check({tag, ".grant"}, 32'(grant_out), 32'(g));
    check({tag, ".index"}, 32'(grant_index_out), 32'(idx));
    check({tag, ".valid"}, 32'(grant_valid_out), 32'(v));
  endtask

  // Structural invariants sampled every cycle once out of reset.
  always @(negedge clk) begin
    if (inv_on) begin
      vectors++;
      assert ($onehot0(grant_out) && (grant_valid_out == (grant_out != 4'b0)) &&
              (!grant_valid_out || grant_out == (4'b0001 << grant_index_out))) else begin
        miscompares++;
        $error("FAIL invariant: observed grant=%b index=%0d valid=%b", grant_out, grant_index_out, grant_valid_out);
      end
    end
  end

  initial begin
    rst = 1'b1; req_in = 4'b1111; grant_ready_in = 1'b0; flush_in = 1'b0;
    // 1. reset
    step(); step();
    expect_grant("reset", 4'b0000, 2'd0, 1'b0);
    inv_on = 1'b1;
    rst = 1'b0;
    step();
    expect_grant("first_after_reset", 4'b0001, 2'd0, 1'b1);
    req_in = 4'b0000; grant_ready_in = 1'b1;
    step();
    expect_grant("release_idle", 4'b0000, 2'd0, 1'b0);      // ptr=1
    // ready with nothing outstanding does nothing
    step();
    expect_grant("ready_while_idle", 4'b0000, 2'd0, 1'b0);

    // 2. single request with hold
    req_in = 4'b0100; grant_ready_in = 1'b0;
    step();
    expect_grant("single", 4'b0100, 2'd2, 1'b1);
    req_in = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_grant("hold", 4'b0100, 2'd2, 1'b1);
    end
    grant_ready_in = 1'b1;
    step();
    expect_grant("hold_release", 4'b0000, 2'd0, 1'b0);       // ptr=3
    grant_ready_in = 1'b0;

    // 4. pointer wrap / skip
    req_in = 4'b0101;
    step();
    expect_grant("wrap", 4'b0001, 2'd0, 1'b1);
    grant_ready_in = 1'b1;
    step();
    expect_grant("skip", 4'b0100, 2'd2, 1'b1);               // ptr=1
    req_in = 4'b0000;
    step();
    expect_grant("skip_release", 4'b0000, 2'd0, 1'b0);       // ptr=3

    // 3. full rotation from ptr=3, no bubbles
    req_in = 4'b1111;
    step(); expect_grant("rot0", 4'b1000, 2'd3, 1'b1);
    step(); expect_grant("rot1", 4'b0001, 2'd0, 1'b1);
    step(); expect_grant("rot2", 4'b0010, 2'd1, 1'b1);
    step(); expect_grant("rot3", 4'b0100, 2'd2, 1'b1);
    step(); expect_grant("rot4", 4'b1000, 2'd3, 1'b1);
    step(); expect_grant("rot5", 4'b0001, 2'd0, 1'b1);       // ptr=0
    grant_ready_in = 1'b0;
    step(); expect_grant("rot_hold", 4'b0001, 2'd0, 1'b1);
    grant_ready_in = 1'b1;
    step(); expect_grant("rot6", 4'b0010, 2'd1, 1'b1);       // ptr=1

    // 5. flush beats handshake
    flush_in = 1'b1;
    step(); expect_grant("flush", 4'b0000, 2'd0, 1'b0);
    flush_in = 1'b0; grant_ready_in = 1'b0;
    step(); expect_grant("after_flush", 4'b0010, 2'd1, 1'b1);

    // 6. end-to-end through selector model
    grant_ready_in = 1'b1;
    step();
    expect_grant("e2e0", 4'b0100, 2'd2, 1'b1);
    check("e2e0.data", 32'(data_out), 32'd2);
    check("e2e0.dvalid", 32'(data_out_valid), 32'd1);
    step();
    check("e2e1.data", 32'(data_out), 32'd3);
    check("e2e1.dvalid", 32'(data_out_valid), 32'd1);
    step();
    check("e2e2.data", 32'(data_out), 32'd0);
    check("e2e2.dvalid", 32'(data_out_valid), 32'd1);
    rst = 1'b1;
    step();
    check("e2e_rst.dvalid", 32'(data_out_valid), 32'd0);
    expect_grant("e2e_rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    expect_grant("e2e_restart", 4'b0001, 2'd0, 1'b1);
    check("e2e_restart.data", 32'(data_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
